// File: rtl/alu_execute_sequencer.sv
// Execute-stage sequencer: dispatches one decoded RV32I ALU instruction at a time
// to a single ALU unit, samples the shared result bus and hands the result to writeback.
module alu_execute_sequencer #(
    parameter int RESULT_LATENCY = 1,
    parameter int XLEN           = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [6:0]      issue_opcode,
    input  logic [4:0]      issue_rd,
    output logic [3:0]      unit_enable,
    input  logic [XLEN-1:0] result_bus,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_value,
    output logic            wb_write_enable,
    output logic            illegal_opcode,
    output logic            busy
);

    localparam logic [3:0] LATENCY = 4'(RESULT_LATENCY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        CAPTURE = 3'd2,
        WB      = 3'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic [3:0] unit_sel;
    logic [4:0] rd_latched;
    logic [3:0] decoded;
    logic       legal;
    logic       in_idle;

    always_comb begin
        decoded = 4'b0000;
        case (issue_opcode)
            7'b0110111: decoded = 4'b0001;
            7'b0010111: decoded = 4'b0010;
            7'b0010011: decoded = 4'b0100;
            7'b0110011: decoded = 4'b1000;
            default:    decoded = 4'b0000;
        endcase
    end

    assign legal       = |decoded;
    assign in_idle     = (state == IDLE);
    assign issue_ready = in_idle && reset_n;
    assign busy        = !in_idle;
    assign unit_enable = (state == EXEC) ? unit_sel : 4'b0000;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue_valid && legal) state_next = EXEC;
            // count holds the remaining enable cycles, including the current one
            EXEC:    if (count <= 4'd1) state_next = CAPTURE;
            CAPTURE: state_next = WB;
            WB:      if (wb_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            count           <= 4'd0;
            unit_sel        <= 4'b0000;
            rd_latched      <= 5'd0;
            wb_valid        <= 1'b0;
            wb_rd           <= 5'd0;
            wb_value        <= '0;
            wb_write_enable <= 1'b0;
            illegal_opcode  <= 1'b0;
        end else begin
            state          <= state_next;
            illegal_opcode <= in_idle && issue_valid && !legal;
            if (in_idle && issue_valid && legal) begin
                unit_sel   <= decoded;
                rd_latched <= issue_rd;
                count      <= LATENCY;
            end
            if (state == EXEC) begin
                count <= count - 4'd1;
            end
            // the enabled unit's registered output is on the bus during CAPTURE
            if (state == CAPTURE) begin
                wb_value        <= result_bus;
                wb_rd           <= rd_latched;
                wb_write_enable <= (rd_latched != 5'd0);
                wb_valid        <= 1'b1;
            end
            if (state == WB && wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_execute_sequencer.sv
// Directed bench for alu_execute_sequencer: one instance at latency 1 and one at latency 3,
// with a registered unit model driving the shared tri-stated result bus.
module tb_alu_execute_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] unit_val;

    logic        issue_valid;
    logic [6:0]  issue_opcode;
    logic [4:0]  issue_rd;
    logic        wb_ready;
    logic        ready1, wbv1, wbwe1, ill1, busy1;
    logic [3:0]  en1;
    logic [4:0]  wbrd1;
    logic [31:0] wbval1;
    logic        drive1;
    wire  [31:0] bus1;

    logic        iv3;
    logic [6:0]  op3;
    logic [4:0]  rd3;
    logic        wr3;
    logic        ready3, wbv3, wbwe3, ill3, busy3;
    logic [3:0]  en3;
    logic [4:0]  wbrd3;
    logic [31:0] wbval3;
    logic        drive3;
    wire  [31:0] bus3;

    int n_vec = 0;
    int n_err = 0;

    assign bus1 = drive1 ? unit_val : 32'bz;
    assign bus3 = drive3 ? unit_val : 32'bz;

    always @(posedge clock) begin
        drive1 <= |en1;
        drive3 <= |en3;
    end

    alu_execute_sequencer #(.RESULT_LATENCY(1), .XLEN(32)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(ready1),
        .issue_opcode(issue_opcode), .issue_rd(issue_rd),
        .unit_enable(en1), .result_bus(bus1),
        .wb_valid(wbv1), .wb_ready(wb_ready), .wb_rd(wbrd1), .wb_value(wbval1),
        .wb_write_enable(wbwe1), .illegal_opcode(ill1), .busy(busy1)
    );

    alu_execute_sequencer #(.RESULT_LATENCY(3), .XLEN(32)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(iv3), .issue_ready(ready3),
        .issue_opcode(op3), .issue_rd(rd3),
        .unit_enable(en3), .result_bus(bus3),
        .wb_valid(wbv3), .wb_ready(wr3), .wb_rd(wbrd3), .wb_value(wbval3),
        .wb_write_enable(wbwe3), .illegal_opcode(ill3), .busy(busy3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction on dut1 and wait for wb_valid, counting edges from the handshake edge.
    task automatic issue1(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val,
                          input logic [3:0] exp_en, input string tag);
        int n;
        @(negedge clock);
        unit_val     = val;
        issue_opcode = op;
        issue_rd     = rd;
        issue_valid  = 1'b1;
        #1 check({tag, "_ready_before"}, ready1, 1);
        @(posedge clock);
        #1 issue_valid = 1'b0;
        check({tag, "_enable"}, en1, exp_en);
        check({tag, "_busy"}, busy1, 1);
        check({tag, "_ready_exec"}, ready1, 0);
        n = 1;
        while (!wbv1 && n < 20) begin
            @(posedge clock);
            #1 n++;
        end
        check({tag, "_latency"}, n, 3);
    endtask

    task automatic accept1(input string tag);
        @(negedge clock);
        wb_ready = 1'b1;
        @(posedge clock);
        #1 wb_ready = 1'b0;
        check({tag, "_wbv_after"}, wbv1, 0);
        check({tag, "_busy_after"}, busy1, 0);
        check({tag, "_ready_after"}, ready1, 1);
    endtask

    initial begin
        int n;
        int en_cycles;
        logic [31:0] held;
        reset_n      = 1'b0;
        unit_val     = 32'h0;
        issue_valid  = 1'b0;
        issue_opcode = 7'h0;
        issue_rd     = 5'h0;
        wb_ready     = 1'b0;
        iv3          = 1'b0;
        op3          = 7'h0;
        rd3          = 5'h0;
        wr3          = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_enable", en1, 0);
        check("rst_busy", busy1, 0);
        check("rst_wbv", wbv1, 0);
        check("rst_wbrd", wbrd1, 0);
        check("rst_wbval", wbval1, 0);
        check("rst_wbwe", wbwe1, 0);
        check("rst_illegal", ill1, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("rst_ready", ready1, 1);

        // auipc, rd=5
        issue1(7'b0010111, 5'd5, 32'h0000_1004, 4'b0010, "auipc");
        check("auipc_wbrd", wbrd1, 5);
        check("auipc_wbval", wbval1, 32'h0000_1004);
        check("auipc_wbwe", wbwe1, 1);
        accept1("auipc");

        // lui to x0 still runs through writeback
        issue1(7'b0110111, 5'd0, 32'hABCD_E000, 4'b0001, "lui_x0");
        check("lui_x0_wbval", wbval1, 32'hABCD_E000);
        check("lui_x0_wbwe", wbwe1, 0);
        check("lui_x0_wbrd", wbrd1, 0);
        accept1("lui_x0");

        // illegal opcode is consumed and flagged for one cycle
        @(negedge clock);
        issue_opcode = 7'b1111111;
        issue_rd     = 5'd3;
        issue_valid  = 1'b1;
        #1 check("ill_ready", ready1, 1);
        @(posedge clock);
        #1 issue_valid = 1'b0;
        check("ill_pulse", ill1, 1);
        check("ill_enable", en1, 0);
        check("ill_busy", busy1, 0);
        check("ill_ready_after", ready1, 1);
        @(posedge clock);
        #1 check("ill_pulse_end", ill1, 0);
        check("ill_wbv", wbv1, 0);

        // wb_ready without wb_valid does nothing
        @(negedge clock);
        wb_ready = 1'b1;
        @(posedge clock);
        #1 wb_ready = 1'b0;
        check("stray_ready_wbv", wbv1, 0);
        check("stray_ready_busy", busy1, 0);

        // writeback back-pressure for 5 cycles with a competing issue
        issue1(7'b0010011, 5'd9, 32'hFFFF_FFF0, 4'b0100, "opimm");
        held = wbval1;
        check("opimm_wbval", wbval1, 32'hFFFF_FFF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            unit_val     = 32'h5555_5555;
            issue_opcode = 7'b0110111;
            issue_rd     = 5'd12;
            issue_valid  = 1'b1;
            @(posedge clock);
            #1;
            check("hold_wbv", wbv1, 1);
            check("hold_wbval", wbval1, held);
            check("hold_wbrd", wbrd1, 9);
            check("hold_ready", ready1, 0);
            check("hold_enable", en1, 0);
        end
        @(negedge clock);
        issue_valid = 1'b0;
        wb_ready    = 1'b1;
        @(posedge clock);
        #1 wb_ready = 1'b0;
        check("hold_release_wbv", wbv1, 0);
        check("hold_release_busy", busy1, 0);
        @(posedge clock);
        #1 check("hold_no_dispatch", en1, 0);
        check("hold_still_idle", busy1, 0);

        // latency 3 instance: op
        @(negedge clock);
        unit_val = 32'h0BAD_F00D;
        op3      = 7'b0110011;
        rd3      = 5'd17;
        iv3      = 1'b1;
        @(posedge clock);
        #1 iv3 = 1'b0;
        n = 1;
        en_cycles = 0;
        while (!wbv3 && n < 20) begin
            if (en3 == 4'b1000) en_cycles++;
            @(posedge clock);
            #1 n++;
        end
        check("op3_enable_cycles", en_cycles, 3);
        check("op3_latency", n, 5);
        check("op3_wbval", wbval3, 32'h0BAD_F00D);
        check("op3_wbrd", wbrd3, 17);
        check("op3_wbwe", wbwe3, 1);
        @(negedge clock);
        wr3 = 1'b1;
        @(posedge clock);
        #1 wr3 = 1'b0;
        check("op3_wbv_after", wbv3, 0);
        check("op3_ready_after", ready3, 1);

        // asynchronous reset in the middle of EXEC
        @(negedge clock);
        unit_val     = 32'h7777_7777;
        issue_opcode = 7'b0110111;
        issue_rd     = 5'd4;
        issue_valid  = 1'b1;
        @(posedge clock);
        #1 issue_valid = 1'b0;
        check("arst_pre_enable", en1, 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        check("arst_enable", en1, 0);
        check("arst_busy", busy1, 0);
        check("arst_wbv", wbv1, 0);
        @(negedge clock);
        reset_n = 1'b1;
        issue1(7'b0110111, 5'd7, 32'h1234_5000, 4'b0001, "lui_post");
        check("lui_post_wbval", wbval1, 32'h1234_5000);
        check("lui_post_wbrd", wbrd1, 7);
        check("lui_post_wbwe", wbwe1, 1);
        accept1("lui_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
